// File: rtl/measure_pkg.sv
// Shared measurement constants and converter state encoding.
// Imported by the cursor measurement path and the BCD readout.
package measure_pkg;

    localparam int MEAS_WIDTH  = 14;
    localparam int MEAS_DIGITS = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction.
// A digit of 5 or more gets +3 so that the next left shift carries into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/measure_bcd.sv
// Sequential binary-to-BCD converter for the measurement readout.
// Converts one bit per clock and publishes digits plus a leading-zero mask.
import measure_pkg::*;

module measure_bcd #(
    parameter int WIDTH  = MEAS_WIDTH,
    parameter int DIGITS = MEAS_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      num,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [DIGITS-1:0] BLANK0 = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t          state;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   scratch_nx;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nx;
    logic [CW-1:0]   count;
    logic [DIGITS-1:0] blank_nx;
    logic            lead;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign {scratch_nx, bin_nx} = {adj, bin} << 1;

    // Digits stay blanked while everything above them is zero.
    always_comb begin
        lead     = 1'b1;
        blank_nx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (scratch_nx[4*i +: 4] != 4'd0)
                lead = 1'b0;
            blank_nx[i] = lead;
        end
        blank_nx[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            scratch <= '0;
            bin     <= '0;
            count   <= '0;
            bcd     <= '0;
            blank   <= BLANK0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin     <= num;
                        scratch <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nx;
                    bin     <= bin_nx;
                    count   <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        bcd   <= scratch_nx;
                        blank <= blank_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
